// File: rtl/hamming_pkg.sv
// Shared widths, FSM encoding and error-pattern helper for the Hamming(7,4)
// codec and its built-in self-test sequencer.
package hamming_pkg;

  localparam int DATA_W    = 4;
  localparam int CODE_W    = 7;
  localparam int SYN_W     = 3;
  localparam int ERR_CASES = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Case 0 is the clean codeword; case k flips codeword bit k-1, which is
  // the bit whose position number (1..7) the decoder reports as syndrome k.
  function automatic logic [CODE_W-1:0] base_pattern(input logic [SYN_W-1:0] e_idx);
    logic [CODE_W-1:0] p;
    p = '0;
    if (e_idx != '0) begin
      p[e_idx - SYN_W'(1)] = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/hamming_case_checker.sv
// Compares one decoder result against the expected data word, the clean
// codeword and the syndrome that the applied case index should produce.
module hamming_case_checker
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] u_exp,
  input  logic [CODE_W-1:0] c_exp,
  input  logic [SYN_W-1:0]  s_exp,
  input  logic [DATA_W-1:0] w,
  input  logic [CODE_W-1:0] d,
  input  logic [SYN_W-1:0]  s,
  output logic              fail
);

  assign fail = (w != u_exp) || (d != c_exp) || (s != s_exp);

endmodule

// File: rtl/hamming_decoder.sv
// Hamming(7,4) single-error-correcting decoder. The syndrome is the
// position number (1..7) of the bit in error, or 0 for a clean word.
module hamming_decoder
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] v,
  output logic [DATA_W-1:0] w,
  output logic [CODE_W-1:0] d,
  output logic [SYN_W-1:0]  s
);

  assign s = {v[3] ^ v[4] ^ v[5] ^ v[6],
              v[1] ^ v[2] ^ v[5] ^ v[6],
              v[0] ^ v[2] ^ v[4] ^ v[6]};

  // Flip the bit the syndrome points at; a zero syndrome leaves v untouched.
  always_comb begin
    d = v;
    if (s != '0) begin
      d[s - SYN_W'(1)] = ~v[s - SYN_W'(1)];
    end
  end

  assign w = {d[6], d[5], d[4], d[2]};

endmodule

// File: rtl/hamming_encoder.sv
// Hamming(7,4) encoder. Codeword bit i sits at position i+1; parity bits
// live at positions 1, 2 and 4, data bits at positions 3, 5, 6 and 7.
module hamming_encoder
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] u,
  output logic [CODE_W-1:0] c
);

  assign c = {u[3], u[2], u[1],
              u[1] ^ u[2] ^ u[3],
              u[0],
              u[0] ^ u[2] ^ u[3],
              u[0] ^ u[1] ^ u[3]};

endmodule

// File: rtl/hamming_sweep_controller.sv
// Built-in self-test for the Hamming(7,4) codec: walks every data word
// through the clean case and all seven single-bit errors, counting failures
// and capturing the first failing case.
module hamming_sweep_controller
  import hamming_pkg::*;
#(
  parameter int NUM_WORDS = 16,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CODE_W-1:0] extra_err,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  fail_count,
  output logic              first_fail_vld,
  output logic [DATA_W-1:0] first_fail_u,
  output logic [CODE_W-1:0] first_fail_e,
  output logic [DATA_W-1:0] cur_u,
  output logic [CODE_W-1:0] cur_e
);

  localparam logic [DATA_W-1:0] LAST_WORD = DATA_W'(NUM_WORDS - 1);
  localparam logic [SYN_W-1:0]  LAST_CASE = SYN_W'(ERR_CASES - 1);

  state_t              state, state_next;
  logic [DATA_W-1:0]   u_idx, u_idx_next;
  logic [SYN_W-1:0]    e_idx, e_idx_next;
  logic [DATA_W-1:0]   cur_u_next;
  logic [CODE_W-1:0]   cur_e_next;
  logic [CNT_W-1:0]    fail_count_next;
  logic                pass_next;
  logic                first_fail_vld_next;
  logic [DATA_W-1:0]   first_fail_u_next;
  logic [CODE_W-1:0]   first_fail_e_next;

  logic [CODE_W-1:0]   code;
  logic [CODE_W-1:0]   received;
  logic [DATA_W-1:0]   dec_w;
  logic [CODE_W-1:0]   dec_d;
  logic [SYN_W-1:0]    dec_s;
  logic                case_fail;

  hamming_encoder u_encoder (
    .u (cur_u),
    .c (code)
  );

  assign received = code ^ cur_e;

  hamming_decoder u_decoder (
    .v (received),
    .w (dec_w),
    .d (dec_d),
    .s (dec_s)
  );

  hamming_case_checker u_checker (
    .u_exp (cur_u),
    .c_exp (code),
    .s_exp (e_idx),
    .w     (dec_w),
    .d     (dec_d),
    .s     (dec_s),
    .fail  (case_fail)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Next-state and next-datapath logic; every register holds by default.
  always_comb begin
    state_next          = state;
    u_idx_next          = u_idx;
    e_idx_next          = e_idx;
    cur_u_next          = cur_u;
    cur_e_next          = cur_e;
    fail_count_next     = fail_count;
    pass_next           = pass;
    first_fail_vld_next = first_fail_vld;
    first_fail_u_next   = first_fail_u;
    first_fail_e_next   = first_fail_e;

    case (state)
      IDLE: begin
        if (start) begin
          fail_count_next     = '0;
          pass_next           = 1'b0;
          first_fail_vld_next = 1'b0;
          first_fail_u_next   = '0;
          first_fail_e_next   = '0;
          u_idx_next          = '0;
          e_idx_next          = '0;
          state_next          = APPLY;
        end
      end

      APPLY: begin
        cur_u_next = u_idx;
        cur_e_next = base_pattern(e_idx) ^ extra_err;
        state_next = CHECK;
      end

      CHECK: begin
        if (case_fail) begin
          if (fail_count != '1) begin
            fail_count_next = fail_count + CNT_W'(1);
          end
          if (!first_fail_vld) begin
            first_fail_vld_next = 1'b1;
            first_fail_u_next   = cur_u;
            first_fail_e_next   = cur_e;
          end
        end
        if ((e_idx == LAST_CASE) && (u_idx == LAST_WORD)) begin
          // Include this last check so pass is already valid during DONE.
          pass_next  = (fail_count_next == '0);
          state_next = DONE;
        end else begin
          if (e_idx == LAST_CASE) begin
            e_idx_next = '0;
            u_idx_next = u_idx + DATA_W'(1);
          end else begin
            e_idx_next = e_idx + SYN_W'(1);
          end
          state_next = APPLY;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      u_idx          <= '0;
      e_idx          <= '0;
      cur_u          <= '0;
      cur_e          <= '0;
      fail_count     <= '0;
      pass           <= 1'b0;
      first_fail_vld <= 1'b0;
      first_fail_u   <= '0;
      first_fail_e   <= '0;
    end else begin
      state          <= state_next;
      u_idx          <= u_idx_next;
      e_idx          <= e_idx_next;
      cur_u          <= cur_u_next;
      cur_e          <= cur_e_next;
      fail_count     <= fail_count_next;
      pass           <= pass_next;
      first_fail_vld <= first_fail_vld_next;
      first_fail_u   <= first_fail_u_next;
      first_fail_e   <= first_fail_e_next;
    end
  end

endmodule

// File: tb/tb_hamming_sweep_controller.sv
// Self-checking bench for hamming_sweep_controller: table of sweep scenarios
// with expected summary results, a per-case scoreboard of applied words and
// error patterns, and a hand-written mid-sweep reset sequence.
module tb_hamming_sweep_controller;
  import hamming_pkg::*;

  localparam int NUM_WORDS = 16;
  localparam int CNT_W     = 8;
  localparam int NUM_CASES = NUM_WORDS * ERR_CASES;
  localparam int NUM_VECS  = 5;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CODE_W-1:0] extra_err;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  fail_count;
  logic              first_fail_vld;
  logic [DATA_W-1:0] first_fail_u;
  logic [CODE_W-1:0] first_fail_e;
  logic [DATA_W-1:0] cur_u;
  logic [CODE_W-1:0] cur_e;

  hamming_sweep_controller #(
    .NUM_WORDS (NUM_WORDS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .extra_err      (extra_err),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_count     (fail_count),
    .first_fail_vld (first_fail_vld),
    .first_fail_u   (first_fail_u),
    .first_fail_e   (first_fail_e),
    .cur_u          (cur_u),
    .cur_e          (cur_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] u;
    logic [CODE_W-1:0] e;
  } case_t;

  typedef struct {
    string             name;
    logic [CODE_W-1:0] mask;
    int                sel_word;
    bit                spam;
    int                exp_fails;
    bit                exp_pass;
    bit                exp_ffv;
    logic [DATA_W-1:0] exp_ffu;
    logic [CODE_W-1:0] exp_ffe;
  } vec_t;

  case_t sb[$];
  vec_t  vecs[NUM_VECS];
  int    checks   = 0;
  int    failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [CODE_W-1:0] basePattern(input int k);
    logic [CODE_W-1:0] one;
    one = 7'd1;
    return (k == 0) ? 7'd0 : (one << (k - 1));
  endfunction

  function automatic logic [CODE_W-1:0] maskFor(input vec_t v, input int u);
    return (v.sel_word < 0 || v.sel_word == u) ? v.mask : 7'd0;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"},           busy,           0);
    checkOutput({tag, " done"},           done,           0);
    checkOutput({tag, " pass"},           pass,           0);
    checkOutput({tag, " fail_count"},     fail_count,     0);
    checkOutput({tag, " first_fail_vld"}, first_fail_vld, 0);
    checkOutput({tag, " first_fail_u"},   first_fail_u,   0);
    checkOutput({tag, " first_fail_e"},   first_fail_e,   0);
    checkOutput({tag, " cur_u"},          cur_u,          0);
    checkOutput({tag, " cur_e"},          cur_e,          0);
  endtask

  // Runs one full sweep: the start edge counts as cycle 1, so done must be
  // high right after the 257th edge and never before it.
  task automatic applyStimulus(input vec_t v);
    case_t exp_case;
    case_t got_case;
    int    early_done;
    sb.delete();
    early_done = 0;
    extra_err  = maskFor(v, 0);
    start      = 1'b1;
    @(posedge clk); #1;
    start = v.spam;
    checkOutput({v.name, " busy_rise"}, busy, 1);
    for (int i = 0; i < NUM_CASES; i++) begin
      int u;
      int k;
      u = i / ERR_CASES;
      k = i % ERR_CASES;
      extra_err  = maskFor(v, u);
      exp_case.u = DATA_W'(u);
      exp_case.e = basePattern(k) ^ extra_err;
      sb.push_back(exp_case);
      if (done) early_done++;
      @(posedge clk); #1;
      got_case = sb.pop_front();
      checkOutput($sformatf("%s cur_u[%0d]", v.name, i), cur_u, got_case.u);
      checkOutput($sformatf("%s cur_e[%0d]", v.name, i), cur_e, got_case.e);
      if (done) early_done++;
      @(posedge clk); #1;
    end
    checkOutput({v.name, " done_at_257"},  done,       1);
    checkOutput({v.name, " done_early"},   early_done, 0);
    checkOutput({v.name, " fail_count"},   fail_count, v.exp_fails);
    checkOutput({v.name, " pass_in_done"}, pass,       v.exp_pass);
    @(posedge clk); #1;
    start     = 1'b0;
    extra_err = 7'd0;
    checkOutput({v.name, " done_single"},    done,           0);
    checkOutput({v.name, " idle_after"},     busy,           0);
    checkOutput({v.name, " pass"},           pass,           v.exp_pass);
    checkOutput({v.name, " fail_count_hold"}, fail_count,    v.exp_fails);
    checkOutput({v.name, " first_fail_vld"}, first_fail_vld, v.exp_ffv);
    checkOutput({v.name, " first_fail_u"},   first_fail_u,   v.exp_ffu);
    checkOutput({v.name, " first_fail_e"},   first_fail_e,   v.exp_ffe);
    checkOutput({v.name, " cur_u_hold"},     cur_u,          NUM_WORDS - 1);
    checkOutput({v.name, " cur_e_hold"},     cur_e,
                basePattern(ERR_CASES - 1) ^ maskFor(v, NUM_WORDS - 1));
    repeat (3) @(posedge clk);
    #1;
    checkOutput({v.name, " pass_held"}, pass, v.exp_pass);
    checkOutput({v.name, " stay_idle"}, busy, 0);
  endtask

  // Start a faulty sweep, reset it at cycle 100, and confirm it stays dead.
  task automatic abortSequence();
    int stray;
    stray     = 0;
    extra_err = 7'd1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    checkOutput("abort pre_reset busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkAllZero("abort");
    rst_n     = 1'b1;
    extra_err = 7'd0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    checkOutput("abort no_done_after", stray, 0);
  endtask

  initial begin
    vecs[0] = '{"clean",        7'h00, -1, 1'b0,   0, 1'b1, 1'b0, 4'd0, 7'h00};
    vecs[1] = '{"mask_bit0",    7'h01, -1, 1'b0, 128, 1'b0, 1'b1, 4'd0, 7'h01};
    vecs[2] = '{"spam_start",   7'h00, -1, 1'b1,   0, 1'b1, 1'b0, 4'd0, 7'h00};
    vecs[3] = '{"word5_only",   7'h03,  5, 1'b0,   8, 1'b0, 1'b1, 4'd5, 7'h03};
    vecs[4] = '{"mask_bit6",    7'h40, -1, 1'b0, 128, 1'b0, 1'b1, 4'd0, 7'h40};

    rst_n     = 1'b0;
    start     = 1'b0;
    extra_err = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset idle_no_start", busy, 0);

    for (int i = 0; i < NUM_VECS; i++) begin
      if (i == 2) begin
        abortSequence();
      end
      $display("[TB] sweep %s", vecs[i].name);
      applyStimulus(vecs[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
